// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the shift-count width helper.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // A counter that must reach WIDTH needs enough bits to hold WIDTH itself.
  function automatic int CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Saturating shift counter with a single-cycle pulse on reaching WIDTH.
// The pulse does not re-fire until clr or rst brings the count back to zero.
module usr_shift_counter
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       inc,
  output logic [CNT_W(WIDTH)-1:0]    cnt,
  output logic                       done
);

  localparam int CW = CNT_W(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // done_d defaults low so the pulse lasts exactly one cycle.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d  = cnt_q + CW'(1);
      done_d = (cnt_q == CNT_MAX - CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal register: hold, parallel load, shift right/left with serial fill,
// shift counter and done pulse. Define USR_ROTATE_EN to add the rot port.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [WIDTH-1:0]        D,
  input  logic                    sin_r,
  input  logic                    sin_l,
`ifdef USR_ROTATE_EN
  input  logic                    rot,
`endif
  output logic [WIDTH-1:0]        Q,
  output logic                    sout_r,
  output logic                    sout_l,
  output logic [CNT_W(WIDTH)-1:0] cnt,
  output logic                    done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             fill_r, fill_l;
  logic             shift_en, load_en;

  // While rotating, the bit leaving one end re-enters at the other.
`ifdef USR_ROTATE_EN
  assign fill_r = rot ? q_q[0]       : sin_r;
  assign fill_l = rot ? q_q[WIDTH-1] : sin_l;
`else
  assign fill_r = sin_r;
  assign fill_l = sin_l;
`endif

  always_comb begin
    q_d      = q_q;
    shift_en = 1'b0;
    load_en  = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHR: begin
          q_d      = {fill_r, q_q[WIDTH-1:1]};
          shift_en = 1'b1;
        end
        MODE_SHL: begin
          q_d      = {q_q[WIDTH-2:0], fill_l};
          shift_en = 1'b1;
        end
        MODE_LOAD: begin
          q_d     = D;
          load_en = 1'b1;
        end
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= RESET_VAL;
    else     q_q <= q_d;
  end

  usr_shift_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (load_en),
    .inc  (shift_en),
    .cnt  (cnt),
    .done (done)
  );

  assign Q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed-vector bench for universal_shift_reg (WIDTH=4, RESET_VAL=0110).
// Rotate vectors are included when USR_ROTATE_EN is defined.
module tb_universal_shift_reg;

  localparam int WIDTH = 4;
  localparam logic [3:0] RV = 4'b0110;

  logic       clk = 1'b0;
  logic       rst, en, sin_r, sin_l, rot;
  logic [1:0] mode;
  logic [3:0] D, Q;
  logic       sout_r, sout_l, done;
  logic [2:0] cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .D      (D),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
`ifdef USR_ROTATE_EN
    .rot    (rot),
`endif
    .Q      (Q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .cnt    (cnt),
    .done   (done)
  );

  typedef struct {
    logic       rst, en;
    logic [1:0] mode;
    logic [3:0] d;
    logic       sr, sl, rot;
    logic [3:0] q;
    logic [2:0] c;
    logic       dn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                              input logic [3:0] d, input logic sr, input logic sl,
                              input logic ro, input logic [3:0] q,
                              input logic [2:0] c, input logic dn);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.d = d; v.sr = sr; v.sl = sl; v.rot = ro;
    v.q = q; v.c = c; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [3:0] act,
                     input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
  endtask

  task automatic drive_cycle(input vec_t v);
    @(negedge clk);
    rst = v.rst; en = v.en; mode = v.mode; D = v.d;
    sin_r = v.sr; sin_l = v.sl; rot = v.rot;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive_cycle(v);
    chk("Q",      idx, Q,               v.q);
    chk("cnt",    idx, {1'b0, cnt},     {1'b0, v.c});
    chk("done",   idx, {3'b0, done},    {3'b0, v.dn});
    chk("sout_r", idx, {3'b0, sout_r},  {3'b0, v.q[0]});
    chk("sout_l", idx, {3'b0, sout_l},  {3'b0, v.q[3]});
  endtask

  initial begin
    int pulses;
    rst = 1'b1; en = 1'b0; mode = 2'b00; D = '0; sin_r = 1'b0; sin_l = 1'b0; rot = 1'b0;

    // rst  en  mode   D      sr  sl  rot  Q      cnt  done
    // reset with en=1, mode=load: reset wins
    vecs.push_back(mk(1, 1, 2'b11, 4'b1111, 0, 0, 0, 4'b0110, 0, 0));
    vecs.push_back(mk(1, 1, 2'b11, 4'b1111, 0, 0, 0, 4'b0110, 0, 0));
    // load then right fill with ones
    vecs.push_back(mk(0, 1, 2'b11, 4'b1010, 0, 0, 0, 4'b1010, 0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 1, 0, 0, 4'b1101, 1, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 1, 0, 0, 4'b1110, 2, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 1, 0, 0, 4'b1111, 3, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 1, 0, 0, 4'b1111, 4, 1));
    vecs.push_back(mk(0, 1, 2'b00, 4'b0000, 1, 1, 0, 4'b1111, 4, 0));
    // left shift, freeze, two more shifts
    vecs.push_back(mk(0, 1, 2'b11, 4'b1010, 0, 0, 0, 4'b1010, 0, 0));
    vecs.push_back(mk(0, 1, 2'b10, 4'b0000, 1, 0, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 0, 2'b10, 4'b0000, 1, 1, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 0, 2'b11, 4'b1111, 1, 1, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 0, 2'b01, 4'b0000, 1, 1, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 1, 2'b10, 4'b0000, 1, 0, 0, 4'b1000, 2, 0));
    vecs.push_back(mk(0, 1, 2'b10, 4'b0000, 1, 0, 0, 4'b0000, 3, 0));
    // saturation: data keeps moving, cnt stays at 4, done once; reload clears
    vecs.push_back(mk(0, 1, 2'b11, 4'b0011, 0, 0, 0, 4'b0011, 0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 1, 0, 0, 4'b1001, 1, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 0, 0, 0, 4'b0100, 2, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 1, 0, 0, 4'b1010, 3, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 0, 0, 0, 4'b0101, 4, 1));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 1, 0, 0, 4'b1010, 4, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 1, 0, 0, 4'b1101, 4, 0));
    vecs.push_back(mk(0, 1, 2'b11, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    // reset mid-shift discards the partial count
    vecs.push_back(mk(0, 1, 2'b11, 4'b1001, 0, 0, 0, 4'b1001, 0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 0, 0, 0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 0, 0, 0, 4'b0010, 2, 0));
    vecs.push_back(mk(1, 1, 2'b01, 4'b0000, 0, 0, 0, 4'b0110, 0, 0));
    vecs.push_back(mk(0, 1, 2'b00, 4'b0000, 0, 0, 0, 4'b0110, 0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 1, 0, 0, 4'b1011, 1, 0));
    // reset beats en=0
    vecs.push_back(mk(1, 0, 2'b01, 4'b0000, 1, 0, 0, 4'b0110, 0, 0));
`ifdef USR_ROTATE_EN
    // rotates ignore serial inputs and count toward done
    vecs.push_back(mk(0, 1, 2'b11, 4'b1010, 0, 0, 0, 4'b1010, 0, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 1, 1, 1, 4'b0101, 1, 0));
    vecs.push_back(mk(0, 1, 2'b10, 4'b0000, 0, 0, 1, 4'b1010, 2, 0));
    vecs.push_back(mk(0, 1, 2'b01, 4'b0000, 0, 1, 1, 4'b0101, 3, 0));
    vecs.push_back(mk(0, 1, 2'b10, 4'b0000, 1, 1, 1, 4'b1010, 4, 1));
    vecs.push_back(mk(0, 1, 2'b10, 4'b0000, 0, 0, 1, 4'b0101, 4, 0));
`endif

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Ten right shifts after a load: exactly one done pulse, cnt pinned at 4.
    drive_cycle(mk(0, 1, 2'b11, 4'b1100, 0, 0, 0, 4'b0000, 0, 0));
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(mk(0, 1, 2'b01, 4'b0000, k[0], 0, 0, 4'b0000, 0, 0));
      if (done === 1'b1) pulses++;
    end
    chk("sat_pulses", 100, pulses[3:0], 4'd1);
    chk("sat_cnt",    100, {1'b0, cnt}, 4'd4);

    // Reset on each of two partial runs: done must never appear.
    pulses = 0;
    for (int r = 0; r < 2; r++) begin
      drive_cycle(mk(0, 1, 2'b11, 4'b0101, 0, 0, 0, 4'b0000, 0, 0));
      for (int k = 0; k < 3; k++) begin
        drive_cycle(mk(0, 1, 2'b10, 4'b0000, 1, 1, 0, 4'b0000, 0, 0));
        if (done === 1'b1) pulses++;
      end
      drive_cycle(mk(1, 1, 2'b10, 4'b0000, 1, 1, 0, 4'b0000, 0, 0));
      if (done === 1'b1) pulses++;
    end
    chk("rst_no_done", 101, pulses[3:0], 4'd0);
    chk("rst_cnt",     101, {1'b0, cnt}, 4'd0);
    chk("rst_q",       101, Q, RV);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal register: a WIDTH-bit register with synchronous reset, clock enable, hold, parallel load, and shift left or right with serial fill. It adds a shift counter and a completion pulse so serialiser and deserialiser logic can tell when a full word has moved through. It is the general-purpose storage and serial-conversion element for datapaths in this codebase and replaces fixed-width plain D registers.

## Interface
Parameters:
- WIDTH, 4, register width in bits; must be ≥ 2.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q on reset.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  clock enable; 0 freezes all state.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- D  input  WIDTH  parallel load data.
- sin_r  input  1  serial input entering at the MSB on a right shift.
- sin_l  input  1  serial input entering at the LSB on a left shift.
- rot  input  1  rotate select; present only with USR_ROTATE_EN.
- Q  output  WIDTH  register contents.
- sout_r  output  1  Q[0], the bit leaving on the next right shift.
- sout_l  output  1  Q[WIDTH-1], the bit leaving on the next left shift.
- cnt  output  $clog2(WIDTH+1)  shifts since last load or reset; saturates at WIDTH.
- done  output  1  one-cycle pulse when cnt reaches WIDTH.

## Operation
- Priority: rst > en > mode.
- rst=1: Q←RESET_VAL, cnt←0, done←0.
- en=0: Q and cnt hold; done←0.
- en=1, mode 00: Q and cnt hold; done←0.
- en=1, mode 01: Q←{sin_r, Q[WIDTH-1:1]}.
- en=1, mode 10: Q←{Q[WIDTH-2:0], sin_l}.
- en=1, mode 11: Q←D, cnt←0, done←0.
- Each enabled shift: cnt←cnt+1, saturating at WIDTH.
- done←1 only on the edge where cnt goes WIDTH-1→WIDTH; otherwise done←0.
- After saturation:
  - Further shifts still move data.
  - cnt stays at WIDTH.
  - done does not re-fire until a load or reset clears cnt.
- sout_r and sout_l are combinational taps of registered Q, so they carry no extra logic delay.

## Timing
- Single-cycle latency: inputs sampled at edge N are reflected on Q, cnt and done after edge N.
- Reset values: Q=RESET_VAL, cnt=0, done=0, sout_r=RESET_VAL[0], sout_l=RESET_VAL[WIDTH-1].
- Reset mid-shift: takes effect at the next edge and discards any partial count; no done pulse.
- Load and shift cannot coincide, because mode is a single field.
- Inputs need to be stable only around the rising edge.

## Configuration
- USR_ROTATE_EN defined:
  - The rot port exists.
  - rot=1 in mode 01 gives Q←{Q[0], Q[WIDTH-1:1]}.
  - rot=1 in mode 10 gives Q←{Q[WIDTH-2:0], Q[WIDTH-1]}.
  - sin_r and sin_l are ignored while rotating.
  - Rotates count as shifts for cnt and done.
- USR_ROTATE_EN undefined:
  - No rot port.
  - Shifts always use serial fill.

## Structure
- Shared package/include usr_pkg holds:
  - the mode encodings MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11;
  - the count-width function CNT_W(WIDTH)=$clog2(WIDTH+1).
- One sub-module, usr_shift_counter:
  - Implements the saturating counter and done pulse.
  - Inputs: clk, rst, clr (load), inc (enabled shift).
  - Parameter: WIDTH.

## Test plan
- Reset: WIDTH=4, RESET_VAL=4'b0110; assert rst for 2 cycles with en=1 and mode=11 -> Q=0110, cnt=0, done=0, sout_r=0, sout_l=0.
- Load then right fill: load D=1010, then 4 cycles of mode 01 with sin_r=1 -> Q=1101, 1110, 1111, 1111; cnt=1..4; done high only after the 4th edge.
- Left shift and freeze:
  - Load 1010; mode 10 with sin_l=0 -> Q=0100.
  - Then en=0 for 3 cycles -> Q=0100 and cnt=1 unchanged.
  - Then two more shifts -> Q=0000, cnt=3, no done.
- Saturation and reload: 6 right shifts after a load -> cnt stops at 4, done fires once; a new load clears cnt to 0.
- Reset mid-operation: rst after 2 of 4 shifts -> Q=RESET_VAL and cnt=0 on the next edge; no done pulse at any point.
- USR_ROTATE_EN:
  - Load 1010; rot=1, mode 01 -> Q=0101.
  - Then mode 10 -> Q=1010.
  - sin_r and sin_l toggling has no effect.
  - done fires after 4 rotates.
